red_pitaya_asg_seq: RTL and testbench
=====================================

Name: red_pitaya_asg_seq

Overview:
Segment sequencer for one double-buffered ASG channel. Holds a small table of waveform parameter sets ("segments"), written by software. Plays them through the channel's two parameter banks ping-pong style, refilling the vacated bank on each buffer-switch event from the channel. Sits between the ASG register bank and the channel's set_*_0 / set_*_1 inputs, and also drives the channel's set_rst.

Parameters:
RSZ, 15, channel buffer address width; size/step/ofs fields are RSZ+16 bits.
NSEG, 8, number of segment table entries (power of 2, 2..16).
SW, $clog2(NSEG), segment index width (localparam).

Ports:
dac_clk_i  in  1  DAC clock, sole clock
dac_rst_i  in  1  synchronous active-high reset
ctl_start_i  in  1  start pulse
ctl_stop_i  in  1  stop pulse
ctl_loop_i  in  1  1 = wrap last->first, 0 = play first..last once
ctl_first_i  in  SW  first segment index
ctl_last_i  in  SW  last segment index
seg_we_i  in  1  table write strobe
seg_addr_i  in  SW  table entry index
seg_fld_i  in  3  field: 0 amp, 1 dc, 2 size, 3 step, 4 ofs, 5 ncyc, 6 rnum, 7 rdly
seg_wdata_i  in  32  field data, LSB-aligned, truncated to field width
sw_evt_i  in  1  channel buffer-switch pulse (trig_done with trig_evt=2)
bank0_o  out  BW  packed parameter set for channel bank 0 (set_*_i_0)
bank1_o  out  BW  packed parameter set for channel bank 1 (set_*_i_1)
chan_rst_o  out  1  to channel set_rst_i
busy_o  out  1  sequence loading or running
seg_idx_o  out  SW  index of segment now playing
seq_end_o  out  1  one-cycle pulse at normal sequence end
irq_o  out  1  segment-advance interrupt (see Optional Feature)
irq_clr_i  in  1  clears irq_o

Behaviour:
- Bank width: BW = 14+14+3*(RSZ+16)+16+16+32. Packing order from LSB: amp, dc, size, step, ofs, ncyc, rnum, rdly.
- Table write takes effect the next cycle. A load in the same cycle as a write to the same entry uses the old value.
- Active bank after channel reset is bank 1. Each sw_evt_i toggles the internal act_bank.
- next(i) = (i==last) ? first : i+1. If last<first, last is treated as first.
- SILENCE = all-zero bank (amp=0, dc=0).
- IDLE: chan_rst_o=1, busy_o=0. On ctl_start_i, go to LOAD_A.
- LOAD_A (1 cycle): bank1_o <= seg[first]; play=first.
- LOAD_B (1 cycle): bank0_o <= (first==last && !loop) ? SILENCE : seg[next(first)].
- RUN: chan_rst_o=0 from the first RUN cycle, so channel restart comes 3 cycles after start.
- In RUN, on sw_evt_i:
  - If play==last and !loop: chan_rst_o=1 next cycle, seq_end_o pulse, go to IDLE.
  - Otherwise: play <= next(play). The vacated bank loads seg[next(next(play))], or SILENCE if that would wrap and !loop. Loads complete the cycle after the event. act_bank toggles.
- sw_evt_i is ignored in IDLE, LOAD_A and LOAD_B.
- ctl_start_i is ignored unless in IDLE.
- ctl_stop_i, from any state: IDLE next cycle. No seq_end_o pulse. Stop wins over start in the same cycle.
- ctl_first/last/loop are sampled at start only; changes while running are ignored.
- seg_idx_o = play, registered.
- Reset: bank0_o=bank1_o=0, chan_rst_o=1, busy_o=0, seg_idx_o=0, seq_end_o=0, irq_o=0, state IDLE, act_bank=1. Reset mid-run aborts immediately with no seq_end_o pulse.

Optional Feature:
- Macro ASG_SEQ_IRQ_EN.
- Defined: irq_o sets on every RUN segment advance and on seq_end. It is sticky until irq_clr_i; a set in the same cycle wins over clear.
- Undefined: irq_o tied 0 and irq_clr_i unused.

Decomposition:
- Package red_pitaya_asg_seq_pkg holds:
  - field-select constants and field widths/offsets;
  - the BW function of RSZ;
  - state encoding (IDLE, LOAD_A, LOAD_B, RUN).
- Sub-module red_pitaya_asg_seq_tbl: NSEG x BW register table with field write port and one combinational entry read port.

Test Plan:
- Write 3 distinct segments (amp 100/200/300); first=0, last=2, loop=0; start -> bank1=seg0, then bank0=seg1, chan_rst_o low 3 cycles after start. Three sw_evt pulses -> seg_idx 0,1,2, vacated bank gets seg2 then SILENCE, third pulse gives seq_end_o and chan_rst_o=1.
- Same setup with loop=1 and 7 sw_evt pulses -> seg_idx 1,2,0,1,2,0,1; busy_o stays 1; no seq_end_o.
- first=last=5, loop=0 -> bank1=seg5, bank0=SILENCE; one sw_evt ends the sequence.
- ctl_stop_i mid-RUN together with sw_evt_i -> IDLE next cycle, no load, no seq_end_o, chan_rst_o=1.
- Write seg1.amp in the same cycle sw_evt_i loads seg1 -> bank gets old amp; a later reload gets the new amp.
- With ASG_SEQ_IRQ_EN, 2 advances then irq_clr_i in the same cycle as a third advance -> irq_o stays 1.

Source files
------------

// File: rtl/red_pitaya_asg_seq_pkg.sv
// Shared definitions for the ASG segment sequencer: parameter-set field layout,
// bank width and sequencer state encoding.
package red_pitaya_asg_seq_pkg;

    localparam logic [2:0] FLD_AMP  = 3'd0;
    localparam logic [2:0] FLD_DC   = 3'd1;
    localparam logic [2:0] FLD_SIZE = 3'd2;
    localparam logic [2:0] FLD_STEP = 3'd3;
    localparam logic [2:0] FLD_OFS  = 3'd4;
    localparam logic [2:0] FLD_NCYC = 3'd5;
    localparam logic [2:0] FLD_RNUM = 3'd6;
    localparam logic [2:0] FLD_RDLY = 3'd7;

    function automatic int unsigned fld_width(input logic [2:0] fld, input int unsigned rsz);
        case (fld)
            FLD_AMP, FLD_DC:              return 14;
            FLD_SIZE, FLD_STEP, FLD_OFS:  return rsz + 16;
            FLD_NCYC, FLD_RNUM:           return 16;
            default:                      return 32;
        endcase
    endfunction

    // Fields are packed LSB-first in select order, so an offset is the sum of lower widths.
    function automatic int unsigned fld_offset(input logic [2:0] fld, input int unsigned rsz);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < 32'(fld); i++)
            off += fld_width(3'(i), rsz);
        return off;
    endfunction

    function automatic int unsigned bank_width(input int unsigned rsz);
        return 14 + 14 + 3 * (rsz + 16) + 16 + 16 + 32;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        RUN
    } seq_state_t;

endpackage

// File: rtl/red_pitaya_asg_seq_tbl.sv
// Segment parameter table: NSEG packed parameter sets, written one field at a
// time, with a single combinational entry read port.
module red_pitaya_asg_seq_tbl
    import red_pitaya_asg_seq_pkg::*;
#(
    parameter  int unsigned RSZ  = 15,
    parameter  int unsigned NSEG = 8,
    localparam int unsigned SW   = $clog2(NSEG),
    localparam int unsigned BW   = bank_width(RSZ)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [SW-1:0] addr,
    input  logic [2:0]    fld,
    input  logic [31:0]   wdata,
    input  logic [SW-1:0] rd_addr,
    output logic [BW-1:0] rd_data
);

    logic [BW-1:0] mem [NSEG];
    logic [BW-1:0] wmask;
    logic [BW-1:0] wbits;
    int unsigned   woff;
    int unsigned   wwid;

    assign woff = fld_offset(fld, RSZ);
    assign wwid = fld_width(fld, RSZ);

    // Mask limits the write to the selected field, truncating wdata to its width.
    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < BW; i++)
            wmask[i] = (i >= woff) && (i < woff + wwid);
        wbits = (BW'(wdata) << woff) & wmask;
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= (mem[addr] & ~wmask) | wbits;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/red_pitaya_asg_seq.sv
// Segment sequencer for one double-buffered ASG channel: plays table segments
// through the two channel banks ping-pong style. Optional IRQ: ASG_SEQ_IRQ_EN.
module red_pitaya_asg_seq
    import red_pitaya_asg_seq_pkg::*;
#(
    parameter  int unsigned RSZ  = 15,
    parameter  int unsigned NSEG = 8,
    localparam int unsigned SW   = $clog2(NSEG),
    localparam int unsigned BW   = bank_width(RSZ)
) (
    input  logic          dac_clk_i,
    input  logic          dac_rst_i,
    input  logic          ctl_start_i,
    input  logic          ctl_stop_i,
    input  logic          ctl_loop_i,
    input  logic [SW-1:0] ctl_first_i,
    input  logic [SW-1:0] ctl_last_i,
    input  logic          seg_we_i,
    input  logic [SW-1:0] seg_addr_i,
    input  logic [2:0]    seg_fld_i,
    input  logic [31:0]   seg_wdata_i,
    input  logic          sw_evt_i,
    output logic [BW-1:0] bank0_o,
    output logic [BW-1:0] bank1_o,
    output logic          chan_rst_o,
    output logic          busy_o,
    output logic [SW-1:0] seg_idx_o,
    output logic          seq_end_o,
    output logic          irq_o,
    input  logic          irq_clr_i
);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic          act_bank;
    logic          loop_r;
    logic [SW-1:0] first_r;
    logic [SW-1:0] last_r;
    logic [SW-1:0] play;
    logic [SW-1:0] play_nxt;
    logic [SW-1:0] rd_addr;
    logic [BW-1:0] rd_data;
    logic [BW-1:0] fill;
    logic          at_end;
    logic          evt_run;
    logic          evt_end;
    logic          evt_adv;

    function automatic logic [SW-1:0] seg_next(input logic [SW-1:0] i,
                                               input logic [SW-1:0] first,
                                               input logic [SW-1:0] last);
        return (i == last) ? first : i + SW'(1);
    endfunction

    red_pitaya_asg_seq_tbl #(
        .RSZ  (RSZ),
        .NSEG (NSEG)
    ) u_tbl (
        .clk     (dac_clk_i),
        .we      (seg_we_i),
        .addr    (seg_addr_i),
        .fld     (seg_fld_i),
        .wdata   (seg_wdata_i),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign play_nxt = seg_next(play, first_r, last_r);
    assign at_end   = (play == last_r) && !loop_r;
    assign evt_run  = (state == RUN) && sw_evt_i && !ctl_stop_i;
    assign evt_end  = evt_run && at_end;
    assign evt_adv  = evt_run && !at_end;
    // Refill after an advance is the segment after the new one; past the end it is silence.
    assign fill     = (!loop_r && play_nxt == last_r) ? '0 : rd_data;

    always_comb begin
        case (state)
            LOAD_A:  rd_addr = first_r;
            LOAD_B:  rd_addr = seg_next(first_r, first_r, last_r);
            default: rd_addr = seg_next(play_nxt, first_r, last_r);
        endcase
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctl_start_i) state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = RUN;
            RUN:     if (evt_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (ctl_stop_i)
            state_nxt = IDLE;
    end

    always_comb begin
        chan_rst_o = (state != RUN);
        busy_o     = (state != IDLE);
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            bank0_o   <= '0;
            bank1_o   <= '0;
            play      <= '0;
            first_r   <= '0;
            last_r    <= '0;
            loop_r    <= 1'b0;
            act_bank  <= 1'b1;
            seq_end_o <= 1'b0;
        end else begin
            seq_end_o <= evt_end;
            if (state != RUN)
                act_bank <= 1'b1;
            case (state)
                IDLE: if (ctl_start_i && !ctl_stop_i) begin
                    first_r <= ctl_first_i;
                    last_r  <= (ctl_last_i < ctl_first_i) ? ctl_first_i : ctl_last_i;
                    loop_r  <= ctl_loop_i;
                end
                LOAD_A: if (!ctl_stop_i) begin
                    bank1_o <= rd_data;
                    play    <= first_r;
                end
                LOAD_B: if (!ctl_stop_i)
                    bank0_o <= (first_r == last_r && !loop_r) ? '0 : rd_data;
                RUN: if (evt_adv) begin
                    play     <= play_nxt;
                    act_bank <= ~act_bank;
                    if (act_bank)
                        bank1_o <= fill;
                    else
                        bank0_o <= fill;
                end
                default: ;
            endcase
        end
    end

    assign seg_idx_o = play;

`ifdef ASG_SEQ_IRQ_EN
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i)
            irq_o <= 1'b0;
        else if (evt_run)
            irq_o <= 1'b1;
        else if (irq_clr_i)
            irq_o <= 1'b0;
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr_i;
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_red_pitaya_asg_seq.sv
// Self-checking bench for red_pitaya_asg_seq: random table contents and run
// settings against a play-list model of the sequencer.
module tb_red_pitaya_asg_seq;

    localparam int unsigned RSZ  = 15;
    localparam int unsigned NSEG = 8;
    localparam int unsigned SW   = 3;
    localparam int unsigned W    = RSZ + 16;
    localparam int unsigned BW   = 14 + 14 + 3 * W + 16 + 16 + 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctl_start = 1'b0;
    logic          ctl_stop = 1'b0;
    logic          ctl_loop = 1'b0;
    logic [SW-1:0] ctl_first = '0;
    logic [SW-1:0] ctl_last = '0;
    logic          seg_we = 1'b0;
    logic [SW-1:0] seg_addr = '0;
    logic [2:0]    seg_fld = '0;
    logic [31:0]   seg_wdata = '0;
    logic          sw_evt = 1'b0;
    logic          irq_clr = 1'b0;
    logic [BW-1:0] bank0;
    logic [BW-1:0] bank1;
    logic          chan_rst;
    logic          busy;
    logic [SW-1:0] seg_idx;
    logic          seq_end;
    logic          irq;

    int            errors = 0;
    int            checks = 0;

    logic [31:0]   mdl [NSEG][8];
    int            f_m, l_m, len;
    bit            lp;
    logic [BW-1:0] eb0, eb1;
    logic          exp_irq = 1'b0;

    red_pitaya_asg_seq #(.RSZ(RSZ), .NSEG(NSEG)) dut (
        .dac_clk_i   (clk),
        .dac_rst_i   (rst),
        .ctl_start_i (ctl_start),
        .ctl_stop_i  (ctl_stop),
        .ctl_loop_i  (ctl_loop),
        .ctl_first_i (ctl_first),
        .ctl_last_i  (ctl_last),
        .seg_we_i    (seg_we),
        .seg_addr_i  (seg_addr),
        .seg_fld_i   (seg_fld),
        .seg_wdata_i (seg_wdata),
        .sw_evt_i    (sw_evt),
        .bank0_o     (bank0),
        .bank1_o     (bank1),
        .chan_rst_o  (chan_rst),
        .busy_o      (busy),
        .seg_idx_o   (seg_idx),
        .seq_end_o   (seq_end),
        .irq_o       (irq),
        .irq_clr_i   (irq_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic int fw(input int f);
        case (f)
            0, 1:    return 14;
            2, 3, 4: return W;
            5, 6:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] fmask(input int f);
        if (fw(f) >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << fw(f)) - 32'h1;
    endfunction

    function automatic logic [BW-1:0] pack(input int a);
        logic [BW-1:0] v;
        int off;
        v = '0;
        off = 0;
        for (int f = 0; f < 8; f++) begin
            v = v | (BW'(mdl[a][f]) << off);
            off += fw(f);
        end
        return v;
    endfunction

    // Parameter set expected at position k of the play list of the current run.
    function automatic logic [BW-1:0] seg_at(input int k);
        if (!lp && k >= len) return '0;
        return pack(f_m + (k % len));
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int f, input logic [31:0] d);
        seg_we = 1'b1; seg_addr = SW'(a); seg_fld = 3'(f); seg_wdata = d;
        tick();
        seg_we = 1'b0;
        mdl[a][f] = d & fmask(f);
    endtask

    task automatic chk_banks(input string tag);
        chk({tag, "_bank0"}, bank0, eb0);
        chk({tag, "_bank1"}, bank1, eb1);
    endtask

    task automatic run(input int f, input int l, input bit lp_i, input int nevt,
                       input int wr_evt, input int wr_a, input int wr_f,
                       input logic [31:0] wr_d, input int clr_evt);
        f_m = f;
        l_m = (l < f) ? f : l;
        len = l_m - f_m + 1;
        lp  = lp_i;
        ctl_first = SW'(f); ctl_last = SW'(l); ctl_loop = lp_i; ctl_start = 1'b1;
        tick();
        ctl_start = 1'b0;
        chk("load_busy", BW'(busy), BW'(1));
        chk("load_chan_rst", BW'(chan_rst), BW'(1));
        // Control changes after start and events during loading must be ignored.
        ctl_first = SW'($urandom); ctl_last = SW'($urandom); ctl_loop = 1'($urandom);
        sw_evt = 1'($urandom);
        tick();
        eb1 = seg_at(0);
        chk("load_a_bank1", bank1, eb1);
        chk("load_a_idx", BW'(seg_idx), BW'(f_m));
        chk("load_a_chan_rst", BW'(chan_rst), BW'(1));
        tick();
        sw_evt = 1'b0;
        eb0 = seg_at(1);
        chk_banks("load_b");
        chk("run_chan_rst", BW'(chan_rst), BW'(0));
        chk("run_busy", BW'(busy), BW'(1));
        for (int e = 1; e <= nevt; e++) begin
            repeat ($urandom_range(0, 3)) begin
                ctl_start = 1'($urandom);
                tick();
                ctl_start = 1'b0;
                chk("gap_seq_end", BW'(seq_end), BW'(0));
            end
            sw_evt = 1'b1;
            if (e == wr_evt) begin
                seg_we = 1'b1; seg_addr = SW'(wr_a); seg_fld = 3'(wr_f); seg_wdata = wr_d;
            end
            if (e == clr_evt) irq_clr = 1'b1;
            tick();
            sw_evt = 1'b0; seg_we = 1'b0; irq_clr = 1'b0;
`ifdef ASG_SEQ_IRQ_EN
            exp_irq = 1'b1;
`endif
            chk("evt_irq", BW'(irq), BW'(exp_irq));
            if (!lp && e == len) begin
                chk("end_seq_end", BW'(seq_end), BW'(1));
                chk("end_chan_rst", BW'(chan_rst), BW'(1));
                chk("end_busy", BW'(busy), BW'(0));
                tick();
                chk("end_seq_end_pulse", BW'(seq_end), BW'(0));
            end else begin
                if ((e + 1) % 2 == 0) eb1 = seg_at(e + 1);
                else                  eb0 = seg_at(e + 1);
                chk_banks("evt");
                chk("evt_idx", BW'(seg_idx), BW'(f_m + (e % len)));
                chk("evt_busy", BW'(busy), BW'(1));
                chk("evt_seq_end", BW'(seq_end), BW'(0));
            end
            if (e == wr_evt) mdl[wr_a][wr_f] = wr_d & fmask(wr_f);
        end
    endtask

    // Stop arrives together with a switch event: nothing must load or advance.
    task automatic stop_run(input logic [SW-1:0] idx_exp);
        ctl_stop = 1'b1; sw_evt = 1'b1;
        tick();
        ctl_stop = 1'b0; sw_evt = 1'b0;
        chk("stop_busy", BW'(busy), BW'(0));
        chk("stop_chan_rst", BW'(chan_rst), BW'(1));
        chk("stop_seq_end", BW'(seq_end), BW'(0));
        chk("stop_idx", BW'(seg_idx), BW'(idx_exp));
        chk("stop_irq", BW'(irq), BW'(exp_irq));
        chk_banks("stop");
    endtask

    task automatic clr_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        exp_irq = 1'b0;
        chk("irq_clear", BW'(irq), BW'(exp_irq));
    endtask

    initial begin
        int f, l, n;
        bit lpr;
        tick();
        tick();
        chk("rst_bank0", bank0, '0);
        chk("rst_bank1", bank1, '0);
        chk("rst_chan_rst", BW'(chan_rst), BW'(1));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_idx", BW'(seg_idx), BW'(0));
        chk("rst_seq_end", BW'(seq_end), BW'(0));
        chk("rst_irq", BW'(irq), BW'(0));
        rst = 1'b0;

        for (int a = 0; a < int'(NSEG); a++)
            for (int fl = 0; fl < 8; fl++)
                wr(a, fl, $urandom);
        wr(0, 0, 32'd100);
        wr(1, 0, 32'd200);
        wr(2, 0, 32'd300);

        // Events and start/stop together while idle change nothing.
        sw_evt = 1'b1; ctl_start = 1'b1; ctl_stop = 1'b1;
        tick();
        sw_evt = 1'b0; ctl_start = 1'b0; ctl_stop = 1'b0;
        chk("idle_start_stop_busy", BW'(busy), BW'(0));
        chk("idle_evt_bank0", bank0, '0);

        run(0, 2, 1'b0, 3, -1, 0, 0, 32'd0, -1);
        clr_irq();

        run(0, 2, 1'b1, 7, 3, 1, 0, 32'd555, 3);
        stop_run(SW'(1));
        clr_irq();

        run(5, 5, 1'b0, 1, -1, 0, 0, 32'd0, -1);

        run(1, 4, 1'b1, 3, -1, 0, 0, 32'd0, -1);
        stop_run(SW'(f_m + (3 % len)));
        clr_irq();

        for (int i = 0; i < 6; i++) begin
            wr($urandom_range(0, NSEG - 1), $urandom_range(0, 7), $urandom);
            f   = $urandom_range(0, NSEG - 1);
            l   = $urandom_range(0, NSEG - 1);
            lpr = 1'($urandom);
            n   = ((l < f) ? 1 : l - f + 1);
            run(f, l, lpr, lpr ? 2 * n + 1 : n, -1, 0, 0, 32'd0, -1);
            if (lpr) stop_run(SW'(f_m + ((2 * n + 1) % len)));
            clr_irq();
        end

        run(0, 7, 1'b1, 2, -1, 0, 0, 32'd0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_irq = 1'b0;
        chk("mid_rst_bank0", bank0, '0);
        chk("mid_rst_bank1", bank1, '0);
        chk("mid_rst_busy", BW'(busy), BW'(0));
        chk("mid_rst_chan_rst", BW'(chan_rst), BW'(1));
        chk("mid_rst_idx", BW'(seg_idx), BW'(0));
        chk("mid_rst_seq_end", BW'(seq_end), BW'(0));
        chk("mid_rst_irq", BW'(irq), BW'(exp_irq));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
